// File: rtl/l2_cache_ctrl_nway.sv
// WAYS-way set-associative write-back/write-allocate L2 control FSM.
// Optional hit/miss/write-back counters are enabled by defining L2_PERF_CNT_EN.
module l2_cache_ctrl_nway #(
  parameter  int WAYS  = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  output logic             o_mem_resp,
  input  logic             i_hit,
  input  logic [WAYS-1:0]  i_hit_way,
  input  logic [WAYS-1:0]  i_valid_vec,
  input  logic [WAYS-1:0]  i_dirty_vec,
  input  logic [WAY_W-1:0] i_lru_victim,
  output logic [WAYS-1:0]  o_load_data,
  output logic [WAYS-1:0]  o_load_tag,
  output logic [WAYS-1:0]  o_load_valid,
  output logic [WAYS-1:0]  o_load_dirty,
  output logic             o_dirty_in,
  output logic             o_fill_sel,
  output logic [WAY_W-1:0] o_wb_sel,
  output logic             o_addr_sel,
  output logic             o_load_lru,
  output logic [WAY_W-1:0] o_lru_way,
  output logic             o_pmem_read,
  output logic             o_pmem_write,
  input  logic             i_pmem_resp,
  output logic             o_busy
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]      o_hit_cnt,
  output logic [31:0]      o_miss_cnt,
  output logic [31:0]      o_wb_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, ALLOCATE} state_t;

  state_t           r_state;
  logic [WAY_W-1:0] r_victim;
  logic [WAY_W-1:0] r_wb_sel;
  logic             r_pmem_read;
  logic             r_pmem_write;
  logic             r_addr_sel;
  logic             r_busy;
  logic             r_alloc;

  logic             w_req;
  logic             w_hit_act;
  logic             w_hit_wr;
  logic             w_miss;
  logic [WAY_W-1:0] w_victim;
  logic [WAY_W-1:0] w_hit_idx;
  logic [WAYS-1:0]  w_victim_oh;
  logic [WAYS-1:0]  w_alloc_vec;
  logic [WAYS-1:0]  w_hit_vec;

  assign w_req     = i_mem_read | i_mem_write;
  assign w_hit_act = i_rst_n & (r_state == IDLE) & w_req & i_hit;
  assign w_hit_wr  = w_hit_act & i_mem_write;
  assign w_miss    = (r_state == IDLE) & w_req & ~i_hit;

  // Lowest invalid way wins; fall back to the replacement unit only when the set is full.
  always_comb begin
    w_victim = i_lru_victim;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!i_valid_vec[i]) w_victim = WAY_W'(i);
    end
  end

  always_comb begin
    w_hit_idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (i_hit_way[i]) w_hit_idx = w_hit_idx | WAY_W'(i);
    end
  end

  assign w_victim_oh = WAYS'(1) << r_victim;
  assign w_alloc_vec = r_alloc  ? w_victim_oh : '0;
  assign w_hit_vec   = w_hit_wr ? i_hit_way   : '0;

  assign o_mem_resp   = w_hit_act;
  assign o_load_lru   = w_hit_act;
  assign o_lru_way    = w_hit_act ? w_hit_idx : '0;
  assign o_load_data  = w_hit_vec | w_alloc_vec;
  assign o_load_dirty = w_hit_vec | w_alloc_vec;
  assign o_load_tag   = w_alloc_vec;
  assign o_load_valid = w_alloc_vec;
  assign o_dirty_in   = w_hit_wr;
  assign o_fill_sel   = w_hit_wr;
  assign o_pmem_read  = r_pmem_read;
  assign o_pmem_write = r_pmem_write;
  assign o_addr_sel   = r_addr_sel;
  assign o_wb_sel     = r_wb_sel;
  assign o_busy       = r_busy;

  // Miss-side outputs are registered alongside the state so they follow it exactly.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_victim     <= '0;
      r_wb_sel     <= '0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_addr_sel   <= 1'b0;
      r_busy       <= 1'b0;
      r_alloc      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_victim <= w_victim;
            r_busy   <= 1'b1;
            if (i_valid_vec[w_victim] && i_dirty_vec[w_victim]) begin
              r_state      <= WRITEBACK;
              r_pmem_write <= 1'b1;
              r_addr_sel   <= 1'b1;
              r_wb_sel     <= w_victim;
            end else begin
              r_state     <= FILL;
              r_pmem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (i_pmem_resp) begin
            r_state      <= FILL;
            r_pmem_write <= 1'b0;
            r_addr_sel   <= 1'b0;
            r_wb_sel     <= '0;
            r_pmem_read  <= 1'b1;
          end
        end
        FILL: begin
          if (i_pmem_resp) begin
            r_state     <= ALLOCATE;
            r_pmem_read <= 1'b0;
            r_alloc     <= 1'b1;
          end
        end
        ALLOCATE: begin
          r_state <= IDLE;
          r_alloc <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef L2_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] r_wb_cnt;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_hit_act && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 32'd1;
      if ((r_state == WRITEBACK) && i_pmem_resp && (r_wb_cnt != '1)) r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
  assign o_wb_cnt   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_l2_cache_ctrl_nway.sv
// Scoreboard bench for l2_cache_ctrl_nway: a 4-way instance carries the main sequences,
// an 8-way instance covers simultaneous read+write on a hit.
module tb_l2_cache_ctrl_nway;

   typedef struct packed {
      logic       memResp;
      logic [7:0] loadData;
      logic [7:0] loadTag;
      logic [7:0] loadValid;
      logic [7:0] loadDirty;
      logic       dirtyIn;
      logic       fillSel;
      logic       loadLru;
      logic [2:0] lruWay;
      logic       pmemRead;
      logic       pmemWrite;
      logic       addrSel;
      logic [2:0] wbSel;
      logic       busy;
   } outs_t;

   logic clk = 1'b0;
   logic rstN = 1'b0;

   logic       memRead4 = 0, memWrite4 = 0, hit4 = 0, pmemResp4 = 0;
   logic [3:0] hitWay4 = 0, validVec4 = 0, dirtyVec4 = 0;
   logic [1:0] lruVictim4 = 0;
   logic       memResp4, dirtyIn4, fillSel4, addrSel4, loadLru4, pmemRead4, pmemWrite4, busy4;
   logic [3:0] loadData4, loadTag4, loadValid4, loadDirty4;
   logic [1:0] wbSel4, lruWay4;

   logic       memRead8 = 0, memWrite8 = 0, hit8 = 0;
   logic [7:0] hitWay8 = 0;
   logic [7:0] validVec8 = 8'hFF, dirtyVec8 = 8'h00;
   logic [2:0] lruVictim8 = 0;
   logic       pmemResp8 = 0;
   logic       memResp8, dirtyIn8, fillSel8, addrSel8, loadLru8, pmemRead8, pmemWrite8, busy8;
   logic [7:0] loadData8, loadTag8, loadValid8, loadDirty8;
   logic [2:0] wbSel8, lruWay8;

`ifdef L2_PERF_CNT_EN
   logic [31:0] hitCnt4, missCnt4, wbCnt4, hitCnt8, missCnt8, wbCnt8;
`endif

   int    compared = 0;
   int    mismatched = 0;
   int    cycleNo = 0;
   bit    monOn = 1'b0;

   outs_t q4[$];
   int    cyc4[$];
   string name4[$];
   outs_t q8[$];
   int    cyc8[$];
   string name8[$];

   outs_t act4, act8;

   always #5 clk = ~clk;
   always @(posedge clk) cycleNo <= cycleNo + 1;

   l2_cache_ctrl_nway #(.WAYS(4)) dut4 (
      .i_clk(clk), .i_rst_n(rstN),
      .i_mem_read(memRead4), .i_mem_write(memWrite4), .o_mem_resp(memResp4),
      .i_hit(hit4), .i_hit_way(hitWay4), .i_valid_vec(validVec4), .i_dirty_vec(dirtyVec4),
      .i_lru_victim(lruVictim4),
      .o_load_data(loadData4), .o_load_tag(loadTag4), .o_load_valid(loadValid4),
      .o_load_dirty(loadDirty4), .o_dirty_in(dirtyIn4), .o_fill_sel(fillSel4),
      .o_wb_sel(wbSel4), .o_addr_sel(addrSel4), .o_load_lru(loadLru4), .o_lru_way(lruWay4),
      .o_pmem_read(pmemRead4), .o_pmem_write(pmemWrite4), .i_pmem_resp(pmemResp4),
      .o_busy(busy4)
`ifdef L2_PERF_CNT_EN
      , .o_hit_cnt(hitCnt4), .o_miss_cnt(missCnt4), .o_wb_cnt(wbCnt4)
`endif
   );

   l2_cache_ctrl_nway #(.WAYS(8)) dut8 (
      .i_clk(clk), .i_rst_n(rstN),
      .i_mem_read(memRead8), .i_mem_write(memWrite8), .o_mem_resp(memResp8),
      .i_hit(hit8), .i_hit_way(hitWay8), .i_valid_vec(validVec8), .i_dirty_vec(dirtyVec8),
      .i_lru_victim(lruVictim8),
      .o_load_data(loadData8), .o_load_tag(loadTag8), .o_load_valid(loadValid8),
      .o_load_dirty(loadDirty8), .o_dirty_in(dirtyIn8), .o_fill_sel(fillSel8),
      .o_wb_sel(wbSel8), .o_addr_sel(addrSel8), .o_load_lru(loadLru8), .o_lru_way(lruWay8),
      .o_pmem_read(pmemRead8), .o_pmem_write(pmemWrite8), .i_pmem_resp(pmemResp8),
      .o_busy(busy8)
`ifdef L2_PERF_CNT_EN
      , .o_hit_cnt(hitCnt8), .o_miss_cnt(missCnt8), .o_wb_cnt(wbCnt8)
`endif
   );

   // Gather each instance's outputs into one zero-extended vector for the monitor.
   always_comb begin
      act4 = '0;
      act4.memResp   = memResp4;
      act4.loadData  = {4'b0, loadData4};
      act4.loadTag   = {4'b0, loadTag4};
      act4.loadValid = {4'b0, loadValid4};
      act4.loadDirty = {4'b0, loadDirty4};
      act4.dirtyIn   = dirtyIn4;
      act4.fillSel   = fillSel4;
      act4.loadLru   = loadLru4;
      act4.lruWay    = {1'b0, lruWay4};
      act4.pmemRead  = pmemRead4;
      act4.pmemWrite = pmemWrite4;
      act4.addrSel   = addrSel4;
      act4.wbSel     = {1'b0, wbSel4};
      act4.busy      = busy4;
   end

   always_comb begin
      act8 = '0;
      act8.memResp   = memResp8;
      act8.loadData  = loadData8;
      act8.loadTag   = loadTag8;
      act8.loadValid = loadValid8;
      act8.loadDirty = loadDirty8;
      act8.dirtyIn   = dirtyIn8;
      act8.fillSel   = fillSel8;
      act8.loadLru   = loadLru8;
      act8.lruWay    = lruWay8;
      act8.pmemRead  = pmemRead8;
      act8.pmemWrite = pmemWrite8;
      act8.addrSel   = addrSel8;
      act8.wbSel     = wbSel8;
      act8.busy      = busy8;
   end

   function automatic outs_t idleOuts();
      outs_t o = '0;
      return o;
   endfunction

   function automatic outs_t hitOuts(input bit wr, input logic [7:0] way, input logic [2:0] idx);
      outs_t o = '0;
      o.memResp = 1'b1;
      o.loadLru = 1'b1;
      o.lruWay  = idx;
      if (wr) begin
         o.loadData  = way;
         o.loadDirty = way;
         o.dirtyIn   = 1'b1;
         o.fillSel   = 1'b1;
      end
      return o;
   endfunction

   function automatic outs_t fillOuts();
      outs_t o = '0;
      o.pmemRead = 1'b1;
      o.busy     = 1'b1;
      return o;
   endfunction

   function automatic outs_t wbOuts(input logic [2:0] sel);
      outs_t o = '0;
      o.pmemWrite = 1'b1;
      o.addrSel   = 1'b1;
      o.wbSel     = sel;
      o.busy      = 1'b1;
      return o;
   endfunction

   function automatic outs_t allocOuts(input logic [7:0] oh);
      outs_t o = '0;
      o.loadData  = oh;
      o.loadTag   = oh;
      o.loadValid = oh;
      o.loadDirty = oh;
      o.busy      = 1'b1;
      return o;
   endfunction

   // wb_sel only matters while writing back, addr_sel only while pmem is being accessed.
   task automatic compareOuts(input string name, input outs_t a, input outs_t e);
      outs_t m = a;
      if (!e.pmemWrite) m.wbSel = '0;
      if (!e.pmemRead && !e.pmemWrite) m.addrSel = 1'b0;
      compared++;
      if (m !== e) begin
         mismatched++;
         $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycleNo, m, e);
      end
   endtask

   task automatic compareVal(input string name, input logic [31:0] a, input logic [31:0] e);
      compared++;
      if (a !== e) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, a, e);
      end
   endtask

   // Monitor: a queued expectation for this cycle is always compared; any other
   // activity on the outputs is an unexpected response.
   always @(negedge clk) begin
      if (monOn) begin
         if (q4.size() > 0 && cyc4[0] == cycleNo) begin
            compareOuts(name4[0], act4, q4[0]);
            void'(q4.pop_front());
            void'(cyc4.pop_front());
            void'(name4.pop_front());
         end else if (act4 != '0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected4 cycle %0d: got %h expected idle", cycleNo, act4);
         end
         if (q8.size() > 0 && cyc8[0] == cycleNo) begin
            compareOuts(name8[0], act8, q8[0]);
            void'(q8.pop_front());
            void'(cyc8.pop_front());
            void'(name8.pop_front());
         end else if (act8 != '0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected8 cycle %0d: got %h expected idle", cycleNo, act8);
         end
      end
   end

   task automatic applyStimulus(input bit rst, input bit rd, input bit wr, input bit hitIn,
                                input logic [3:0] way, input logic [3:0] valid,
                                input logic [3:0] dirty, input logic [1:0] lru, input bit presp);
      @(posedge clk);
      #1;
      rstN       = rst;
      memRead4   = rd;
      memWrite4  = wr;
      hit4       = hitIn;
      hitWay4    = way;
      validVec4  = valid;
      dirtyVec4  = dirty;
      lruVictim4 = lru;
      pmemResp4  = presp;
   endtask

   task automatic applyStimulus8(input bit rd, input bit wr, input bit hitIn, input logic [7:0] way);
      @(posedge clk);
      #1;
      memRead8  = rd;
      memWrite8 = wr;
      hit8      = hitIn;
      hitWay8   = way;
   endtask

   task automatic checkOutput(input bit wide, input string name, input outs_t e);
      if (wide) begin
         q8.push_back(e);
         cyc8.push_back(cycleNo);
         name8.push_back(name);
      end else begin
         q4.push_back(e);
         cyc4.push_back(cycleNo);
         name4.push_back(name);
      end
   endtask

   initial begin
      // Two reset edges, then outputs must all be quiet.
      applyStimulus(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
      applyStimulus(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
      monOn = 1'b1;
      checkOutput(0, "resetIdle", idleOuts());

      // Hits complete in the request cycle.
      applyStimulus(1, 1, 0, 1, 4'b0100, 4'hF, 4'h0, 2'd0, 0);
      checkOutput(0, "readHit", hitOuts(0, 8'h04, 3'd2));
      applyStimulus(1, 0, 0, 0, 4'h0, 4'hF, 4'h0, 2'd0, 0);
      applyStimulus(1, 0, 1, 1, 4'b0001, 4'hF, 4'h0, 2'd0, 0);
      checkOutput(0, "writeHit", hitOuts(1, 8'h01, 3'd0));

      // Clean read miss: way 2 is the lowest invalid way, so no write-back.
      applyStimulus(1, 1, 0, 0, 4'h0, 4'b1011, 4'b1111, 2'd0, 0);
      checkOutput(0, "missEntry1", idleOuts());
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 0, 4'h0, 4'b1011, 4'b1111, 2'd0, (i == 2));
         checkOutput(0, "fill1", fillOuts());
      end
      applyStimulus(1, 1, 0, 0, 4'h0, 4'b1011, 4'b1111, 2'd0, 1);
      checkOutput(0, "alloc1", allocOuts(8'h04));
      applyStimulus(1, 1, 0, 1, 4'b0100, 4'hF, 4'hF, 2'd0, 0);
      checkOutput(0, "missHit1", hitOuts(0, 8'h04, 3'd2));
      applyStimulus(1, 0, 0, 0, 4'h0, 4'hF, 4'h0, 2'd0, 0);

      // Fresh reset, then a dirty write miss evicting the LRU way 3.
      applyStimulus(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
      checkOutput(0, "midReset", idleOuts());
      applyStimulus(1, 0, 1, 0, 4'h0, 4'b1111, 4'b1000, 2'd3, 0);
      checkOutput(0, "missEntry2", idleOuts());
      applyStimulus(1, 0, 1, 0, 4'h0, 4'b1111, 4'b1000, 2'd3, 0);
      checkOutput(0, "writeback0", wbOuts(3'd3));
      applyStimulus(1, 0, 1, 0, 4'h0, 4'b1111, 4'b1000, 2'd3, 1);
      checkOutput(0, "writeback1", wbOuts(3'd3));
      applyStimulus(1, 0, 1, 0, 4'h0, 4'b1111, 4'b1000, 2'd3, 1);
      checkOutput(0, "fill2", fillOuts());
      applyStimulus(1, 0, 1, 0, 4'h0, 4'b1111, 4'b1000, 2'd3, 0);
      checkOutput(0, "alloc2", allocOuts(8'h08));
      applyStimulus(1, 0, 1, 1, 4'b1000, 4'b1111, 4'b1111, 2'd3, 0);
      checkOutput(0, "writeMissHit", hitOuts(1, 8'h08, 3'd3));
      applyStimulus(1, 0, 0, 0, 4'h0, 4'hF, 4'h0, 2'd0, 0);
`ifdef L2_PERF_CNT_EN
      compareVal("hitCnt", hitCnt4, 32'd1);
      compareVal("missCnt", missCnt4, 32'd1);
      compareVal("wbCnt", wbCnt4, 32'd1);
`endif

      // Reset for two cycles during FILL, even with pmem_resp high at the reset edge.
      applyStimulus(1, 1, 0, 0, 4'h0, 4'b0000, 4'b0000, 2'd2, 0);
      checkOutput(0, "missEntry3", idleOuts());
      applyStimulus(1, 1, 0, 0, 4'h0, 4'b0000, 4'b0000, 2'd2, 0);
      checkOutput(0, "fill3", fillOuts());
      applyStimulus(0, 1, 0, 0, 4'h0, 4'b0000, 4'b0000, 2'd2, 1);
      checkOutput(0, "fillAtReset", fillOuts());
      applyStimulus(0, 1, 0, 0, 4'h0, 4'b0000, 4'b0000, 2'd2, 0);
      checkOutput(0, "resetDropsRead", idleOuts());
      applyStimulus(1, 0, 0, 0, 4'h0, 4'b0000, 4'b0000, 2'd2, 0);
      checkOutput(0, "resetNoAlloc", idleOuts());

      // Requester drops the read mid-fill: fill still completes, no response.
      applyStimulus(1, 1, 0, 0, 4'h0, 4'b1111, 4'b0000, 2'd1, 0);
      checkOutput(0, "missEntry4", idleOuts());
      applyStimulus(1, 0, 0, 0, 4'h0, 4'b1111, 4'b0000, 2'd1, 1);
      checkOutput(0, "fill4", fillOuts());
      applyStimulus(1, 0, 0, 0, 4'h0, 4'b1111, 4'b0000, 2'd1, 0);
      checkOutput(0, "alloc4", allocOuts(8'h02));
      applyStimulus(1, 0, 0, 0, 4'h0, 4'b1111, 4'b0000, 2'd1, 0);
      checkOutput(0, "dropNoResp", idleOuts());

      // A stray pmem_resp in IDLE does nothing.
      applyStimulus(1, 0, 0, 0, 4'h0, 4'b1111, 4'b0000, 2'd1, 1);
      checkOutput(0, "idlePmemResp", idleOuts());
      applyStimulus(1, 0, 0, 0, 4'h0, 4'b1111, 4'b0000, 2'd1, 0);

      // 8-way: read and write together on a hit behave as a single write.
      applyStimulus8(1, 1, 1, 8'h20);
      checkOutput(1, "bothHit8", hitOuts(1, 8'h20, 3'd5));
      applyStimulus8(0, 0, 0, 8'h00);
      checkOutput(1, "bothHit8Once", idleOuts());

      repeat (3) @(posedge clk);
      #1;
      compareVal("leftover4", q4.size(), 32'd0);
      compareVal("leftover8", q8.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/l2_cache_ctrl_nway.md
Name: l2_cache_ctrl_nway

Overview:
- Parametrised successor to the fixed 4-way L2 controller.
- Generic WAYS-way set-associative write-back/write-allocate control FSM. Sits between the L1/arbiter request port (mem_*) and physical memory (pmem_*), and drives the per-way data, tag, valid and dirty arrays and the replacement unit.
- New over the previous generation:
  - victim chosen per-set, preferring invalid ways;
  - write-back only when the victim itself is valid and dirty;
  - explicit LRU update;
  - synchronous reset.

Parameters:
- WAYS, 4, number of ways; power of two, 2..16.
- WAY_W, $clog2(WAYS), width of way index (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_read  in  1  CPU-side read request, held until mem_resp.
- mem_write  in  1  CPU-side write request, held until mem_resp.
- mem_resp  out  1  one-cycle response pulse.
- hit  in  1  tag match on a valid way (combinational from datapath).
- hit_way  in  WAYS  one-hot matching way; valid only when hit=1.
- valid_vec  in  WAYS  valid bits of the indexed set.
- dirty_vec  in  WAYS  dirty bits of the indexed set.
- lru_victim  in  WAY_W  replacement unit's victim for the indexed set.
- load_data  out  WAYS  per-way data array write enable.
- load_tag  out  WAYS  per-way tag write enable.
- load_valid  out  WAYS  per-way valid write enable (writes 1).
- load_dirty  out  WAYS  per-way dirty write enable.
- dirty_in  out  1  value written on load_dirty.
- fill_sel  out  1  data source: 0 = pmem line, 1 = CPU write merge.
- wb_sel  out  WAY_W  way muxed onto pmem write data.
- addr_sel  out  1  pmem address: 0 = request tag, 1 = victim tag.
- load_lru  out  1  replacement unit update strobe.
- lru_way  out  WAY_W  most-recently-used way for the update.
- pmem_read  out  1  physical read request, held until pmem_resp.
- pmem_write  out  1  physical write request, held until pmem_resp.
- pmem_resp  in  1  physical memory completion.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: when rst_n is sampled 0 at a clock edge:
  - state is IDLE;
  - victim register is 0;
  - every output is 0 (combinational outputs are 0 because IDLE has no request active or because reset gates them).
  - Reset mid-WRITEBACK or mid-FILL abandons the transaction: pmem_read and pmem_write drop in the cycle after the reset edge, and no array write occurs.
- States: IDLE, WRITEBACK, FILL, ALLOCATE.
- Request: req = mem_read | mem_write. If both are asserted, the request is treated as a write.
- Victim select, latched on the IDLE miss edge:
  - the lowest-index way with valid_vec=0 if any;
  - otherwise lru_victim.
- IDLE:
  - req & hit:
    - mem_resp=1 in the same cycle;
    - load_lru=1 and lru_way=index(hit_way).
    - On a write additionally: load_data[hit]=1, fill_sel=1, load_dirty[hit]=1, dirty_in=1.
    - Stay in IDLE.
  - req & !hit:
    - latch the victim;
    - go to WRITEBACK if valid_vec[v] & dirty_vec[v], else go to FILL;
    - no outputs asserted this cycle.
  - !req: stay in IDLE; no outputs.
- WRITEBACK:
  - pmem_write=1, addr_sel=1, wb_sel=victim.
  - On pmem_resp go to FILL; otherwise stay.
- FILL:
  - pmem_read=1, addr_sel=0.
  - On pmem_resp go to ALLOCATE; otherwise stay.
- ALLOCATE (exactly 1 cycle):
  - load_data[v]=1, fill_sel=0, load_tag[v]=1, load_valid[v]=1, load_dirty[v]=1, dirty_in=0.
  - Go to IDLE.
  - The held request then hits in IDLE and completes there, including the write merge and dirty set.
- Latency, counted from request assertion to mem_resp:
  - hit: 0 cycles;
  - clean miss: 1 + F + 1 cycles then the hit cycle, where F is FILL cycles including the pmem_resp cycle;
  - dirty miss: adds W WRITEBACK cycles.
- pmem_resp while in IDLE or ALLOCATE is ignored.
- pmem_read and pmem_write are never asserted together.
- At most one bit is set in each of load_data, load_tag, load_valid and load_dirty in any cycle.
- Request dropped by the requester while the FSM is busy: the FSM still completes the fill and returns to IDLE; mem_resp is not asserted.

Optional Feature:
- Macro: L2_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt, miss_cnt and wb_cnt, each 32 bits.
  - hit_cnt counts IDLE hit responses. miss_cnt counts IDLE miss entries. wb_cnt counts WRITEBACK completions (on pmem_resp).
  - All counters clear on reset and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with rst_n=0 for 2 cycles while in FILL with pmem_read=1 -> pmem_read=0 the next cycle, state IDLE, busy=0, no load_* strobes.
- WAYS=4, read hit hit_way=4'b0100 -> mem_resp=1 the same cycle, load_lru=1, lru_way=2, no load_data.
- Write hit hit_way=4'b0001 -> load_data=4'b0001, fill_sel=1, load_dirty=4'b0001, dirty_in=1, mem_resp=1.
- Read miss, valid_vec=4'b1011, dirty_vec=4'b1111, lru_victim=0 -> victim 2, no WRITEBACK, FILL with pmem_resp after 3 cycles, ALLOCATE sets load_tag=4'b0100 and load_valid=4'b0100, mem_resp 1 cycle later.
- Write miss, valid_vec=4'b1111, dirty_vec=4'b1000, lru_victim=3 -> WRITEBACK with wb_sel=3 and addr_sel=1, then FILL, ALLOCATE into way 3, then write hit sets dirty; with L2_PERF_CNT_EN: miss_cnt=1, wb_cnt=1, hit_cnt=1.
- WAYS=8, mem_read and mem_write both asserted on a hit -> handled as a write: load_data one-hot at hit_way, single mem_resp pulse.
